// File: rtl/rf_write_arbiter_if.sv
// Write-request bundle between two requesters, the arbiter and the register-file write port.
interface rf_write_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic [4:0]       req0_addr;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [4:0]       req1_addr;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic             init_done;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_wa, rf_wd, init_done
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_wa, rf_wd, init_done
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter for a 32-entry register file; scrubs every entry to zero
// after reset before any request is granted.
module rf_write_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StInit, StArb} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q;
  logic             ptr_q;
  logic             we_q;
  logic [4:0]       wa_q;
  logic [WIDTH-1:0] wd_q;
  logic             ready0, ready1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StInit && cnt_q == 5'd31) begin
      state_d = StArb;
    end
  end

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (state_q == StArb) begin
      ready0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
      ready1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ptr_q <= 1'b0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
    end else if (state_q == StInit) begin
      we_q  <= 1'b1;
      wa_q  <= cnt_q;
      wd_q  <= '0;
      cnt_q <= cnt_q + 5'd1;
    end else if (ready0) begin
      we_q  <= (bus.req0_addr != 5'd0);
      wa_q  <= bus.req0_addr;
      wd_q  <= bus.req0_data;
      ptr_q <= 1'b1;
    end else if (ready1) begin
      we_q  <= (bus.req1_addr != 5'd0);
      wa_q  <= bus.req1_addr;
      wd_q  <= bus.req1_data;
      ptr_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rf_we      = we_q;
  assign bus.rf_wa      = wa_q;
  assign bus.rf_wd      = wd_q;
  assign bus.init_done  = (state_q == StArb);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural register-file model behind it.
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.WIDTH(32)) bus ();

  rf_write_arbiter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [32];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (bus.rf_we) begin
      mem[bus.rf_wa] <= bus.rf_wd;
    end
  end

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
  endtask

  // Called just after rst falls; returns 1 time unit after scrub edge 32.
  task automatic run_scrub(input string tag);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("%s ready0 pre-edge %0d", tag, k + 1), {31'd0, bus.req0_ready}, 32'd0);
      chk($sformatf("%s ready1 pre-edge %0d", tag, k + 1), {31'd0, bus.req1_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("%s we edge %0d", tag, k + 1), {31'd0, bus.rf_we}, 32'd1);
      chk($sformatf("%s wa edge %0d", tag, k + 1), {27'd0, bus.rf_wa}, k);
      chk($sformatf("%s wd edge %0d", tag, k + 1), bus.rf_wd, 32'd0);
      chk($sformatf("%s init_done edge %0d", tag, k + 1), {31'd0, bus.init_done},
          (k == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    bit found;
    // Post-scrub table; pointer starts at requester 0.
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd31,
                32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5'd5,
                32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd5,
                32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd1,  32'h11,       1'b1, 5'd9,  32'h99,       1'b1, 1'b0, 1'b1, 5'd1,
                32'h11};
    vecs[4] = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd9,  32'h99,       1'b0, 1'b1, 1'b1, 5'd9,
                32'h99};
    vecs[5] = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd10, 32'hAA,       1'b1, 1'b0, 1'b1, 5'd2,
                32'h22};
    vecs[6] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd10, 32'hAA,       1'b0, 1'b1, 1'b1, 5'd10,
                32'hAA};
    vecs[7] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,
                32'h1234};
    vecs[8] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd11, 32'hBB,       1'b0, 1'b1, 1'b1, 5'd11,
                32'hBB};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd11,
                32'hBB};

    // Reset with nonzero register contents and both requesters pending.
    drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444);
    preload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk("reset we", {31'd0, bus.rf_we}, 32'd0);
    chk("reset wa", {27'd0, bus.rf_wa}, 32'd0);
    chk("reset wd", bus.rf_wd, 32'd0);
    chk("reset init_done", {31'd0, bus.init_done}, 32'd0);
    chk("reset ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("reset ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("preload took", mem[7], 32'hA5A5_0007);
    rst = 1'b0;
    run_scrub("scrub");
    chk("first ready0 after scrub", {31'd0, bus.req0_ready}, 32'd1);
    chk("first ready1 after scrub", {31'd0, bus.req1_ready}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) chk($sformatf("scrubbed reg %0d", i), mem[i], 32'd0);

    // Table-driven arbitration vectors.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("vec%0d ready0", i), {31'd0, bus.req0_ready}, {31'd0, vecs[i].r0});
      chk($sformatf("vec%0d ready1", i), {31'd0, bus.req1_ready}, {31'd0, vecs[i].r1});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d we", i), {31'd0, bus.rf_we}, {31'd0, vecs[i].we});
      chk($sformatf("vec%0d wa", i), {27'd0, bus.rf_wa}, {27'd0, vecs[i].wa});
      chk($sformatf("vec%0d wd", i), bus.rf_wd, vecs[i].wd);
    end
    chk("reg 5", mem[5], 32'hDEADBEEF);
    chk("reg 1", mem[1], 32'h11);
    chk("reg 9", mem[9], 32'h99);
    chk("reg 2", mem[2], 32'h22);
    chk("reg 10", mem[10], 32'hAA);
    chk("reg 11", mem[11], 32'hBB);
    chk("reg 3 untouched", mem[3], 32'd0);
    chk("reg 0 stays zero", mem[0], 32'd0);

    // Reset mid-scrub at address 17.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.rf_wa == 5'd17) found = 1'b1;
    end
    chk("reached scrub addr 17", {31'd0, found}, 32'd1);
    chk("we at addr 17", {31'd0, bus.rf_we}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-scrub rst drops we", {31'd0, bus.rf_we}, 32'd0);
    chk("mid-scrub rst clears wa", {27'd0, bus.rf_wa}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_scrub("rescrub");

    // Reset mid-ARB with continuous traffic; pointer is at requester 1 when rst hits.
    @(negedge clk);
    drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("traffic wa %0d", c), {27'd0, bus.rf_wa}, (c == 1) ? 32'd21 : 32'd20);
    end
    chk("traffic we before rst", {31'd0, bus.rf_we}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-arb rst drops we", {31'd0, bus.rf_we}, 32'd0);
    chk("mid-arb rst drops init_done", {31'd0, bus.init_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_scrub("arbscrub");
    chk("resume ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("resume ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("resume wa", {27'd0, bus.rf_wa}, 32'd20);
    chk("resume wd", bus.rf_wd, 32'h2020);
    chk("resume ready1 next", {31'd0, bus.req1_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
